mem_stream_ctrl: RTL and testbench
==================================

# mem_stream_ctrl

Stream-to-memory controller that sits directly upstream of the 16x8 single-port `memory` block and owns all of its ports. It takes a valid/ready byte stream and writes it into consecutive memory locations. It reads the stored bytes back in FIFO order and presents them on a valid/ready output stream. Because the memory has a single address port, the block arbitrates every cycle between one write and one read.

## Interface
- DATA_W, 8, data width; must match the memory word width
- ADDR_W, 4, memory address width; depth DEPTH = 2**ADDR_W (16)

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid && s_ready at posedge clk
- s_data  in  DATA_W  input byte
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accepts output byte at posedge clk
- m_data  out  DATA_W  output byte
- level  out  ADDR_W+1  words stored in memory and not yet read (0..16)
- mem_wr_en  out  1  to memory wr_en
- mem_rd_en  out  1  to memory rd_en
- mem_addr  out  ADDR_W  to memory addr
- mem_data_in  out  DATA_W  to memory data_in
- mem_data_out  in  DATA_W  from memory data_out

## Operation
- Memory contract:
  - The memory writes mem_data_in to mem_addr at the posedge where mem_wr_en=1.
  - The memory registers mem_data_out at the posedge where mem_rd_en=1, so the data is valid in the following cycle.
- State:
  - wptr and rptr, each ADDR_W bits; both wrap from 15 to 0 naturally.
  - level, ADDR_W+1 bits.
  - rd_pend flag, 1 bit.
  - Output register m_data/m_valid.
- Read grant, rd_go = (level != 0) && !rd_pend && !m_valid:
  - Drives mem_rd_en=1 and mem_addr=rptr.
  - At the posedge: rptr+1, level-1, rd_pend set.
- Cycle with rd_pend=1:
  - m_data <= mem_data_out, m_valid <= 1 and rd_pend <= 0 at the posedge.
  - rd_pend and m_valid are never 1 together.
- Output handshake: m_valid clears at the posedge where m_valid && m_ready. m_data holds its value until the next capture.
- Write ready: s_ready = (level != DEPTH) && !rd_go && !reset. Read has priority over write.
- Write accept (s_valid && s_ready):
  - Drives mem_wr_en=1, mem_addr=wptr and mem_data_in=s_data.
  - At the posedge: wptr+1, level+1.
- Idle cycles: mem_addr=wptr and mem_data_in=s_data. Both enables are 0.
- Memory-port outputs are combinational from the current grant and registered pointers. They are never registered.
- mem_wr_en and mem_rd_en are never both 1 in the same cycle.
- level arithmetic: write and read grants are mutually exclusive, so level changes by exactly +1, -1 or 0 per cycle.
- Full (level=16): s_ready=0 and no write.
- Empty (level=0): no read. m_valid may still be 1 from an earlier read.
- Maximum output throughput is one byte per 3 cycles. The sequence is read-issue, then capture, then m_valid for at least one cycle.

## Timing
- Reset values (asynchronous, immediate):
  - wptr=0, rptr=0, level=0, rd_pend=0.
  - m_valid=0, m_data=0.
  - s_ready=0 while reset=1.
  - mem_wr_en=0, mem_rd_en=0, mem_addr=0.
- Reset mid-operation: a read in flight is discarded and m_valid stays 0. Memory contents are not cleared, but they are unreachable because the pointers are reset.
- First write after reset can be accepted in the first cycle with reset=0.
- Write-to-output latency with an empty pipeline and m_ready=1:
  - Byte accepted at edge N.
  - rd_go in cycle N+1.
  - m_valid=1 in cycle N+3, after capture at edge N+2.
- s_ready may depend combinationally on m_valid and level, but never on s_valid.
- m_valid and m_data depend only on registers. m_valid never drops without a handshake, and m_data never changes while m_valid=1.

## Test plan
- Reset: assert reset with s_valid=1 and s_data=0xAA → all outputs 0, level=0, no memory enable pulses while reset=1.
- Fill: m_ready=0, then drive s_valid=1 continuously with bytes 0x10..0x20 (17 bytes) → all 17 bytes are accepted.
  - The cycle after the first accept shows s_ready=0 and mem_rd_en=1 with mem_addr=0.
  - Afterwards m_valid=1 with m_data=0x10, level=16, and s_ready=0 for the rest of the run.
- Drain: from the full state set m_ready=1 and s_valid=0 → m_data sequence is 0x10..0x20 in order. Consecutive m_valid pulses are spaced 3 cycles apart. level reaches 0 and m_valid then drops.
- Wrap-around: stream 40 random bytes with m_ready=1 → the output sequence equals the input sequence exactly, and wptr/rptr wrap 15→0 at least twice.
- Collision: hold s_valid=1 while rd_go fires → s_ready=0 in that cycle. mem_wr_en && mem_rd_en is never 1 on any cycle, which the bench checks continuously.
- Reset mid-read: assert reset in the cycle after mem_rd_en=1 → after release m_valid=0, level=0. The next written byte 0x5C is the first byte out.

Source files
------------

// File: rtl/mem_stream_ctrl_if.sv
// Bundle of the byte-stream handshakes and the single-port memory bus around mem_stream_ctrl.
// The master modport is the controller's view; slave is the surrounding stream sources/sinks and memory.
interface mem_stream_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W:0]   level;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    input  s_valid, s_data, m_ready, mem_data_out,
    output s_ready, m_valid, m_data, level,
           mem_wr_en, mem_rd_en, mem_addr, mem_data_in
  );

  modport slave (
    output s_valid, s_data, m_ready, mem_data_out,
    input  s_ready, m_valid, m_data, level,
           mem_wr_en, mem_rd_en, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_stream_ctrl.sv
// Stream-to-memory FIFO controller: writes an input byte stream into a single-port
// memory and reads it back in order, arbitrating one access per cycle (read first).
module mem_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_stream_ctrl_if.master    bus
);
  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(1 << ADDR_W);

  logic [ADDR_W-1:0] wptr_reg, wptr_next;
  logic [ADDR_W-1:0] rptr_reg, rptr_next;
  logic [ADDR_W:0]   level_reg, level_next;
  logic              rd_pend_reg, rd_pend_next;
  logic              m_valid_reg, m_valid_next;
  logic [DATA_W-1:0] m_data_reg, m_data_next;

  logic rd_go;
  logic wr_go;
  logic s_ready_c;

  // A read is only issued when nothing is in flight and the output register is free,
  // so the captured word never has to wait for space.
  always_comb begin
    rd_go     = (level_reg != '0) && !rd_pend_reg && !m_valid_reg;
    s_ready_c = (level_reg != LEVEL_FULL) && !rd_go && !reset;
    wr_go     = bus.s_valid && s_ready_c;
  end

  always_comb begin
    wptr_next    = wptr_reg;
    rptr_next    = rptr_reg;
    level_next   = level_reg;
    rd_pend_next = rd_go;
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;

    if (wr_go) wptr_next = wptr_reg + 1'b1;
    if (rd_go) rptr_next = rptr_reg + 1'b1;

    if (wr_go)      level_next = level_reg + 1'b1;
    else if (rd_go) level_next = level_reg - 1'b1;

    if (rd_pend_reg) begin
      m_data_next  = bus.mem_data_out;
      m_valid_next = 1'b1;
    end else if (m_valid_reg && bus.m_ready) begin
      m_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      level_reg   <= '0;
      rd_pend_reg <= 1'b0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      wptr_reg    <= wptr_next;
      rptr_reg    <= rptr_next;
      level_reg   <= level_next;
      rd_pend_reg <= rd_pend_next;
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
    end
  end

  // Memory port is driven straight from the grant so the access lands on this edge.
  always_comb begin
    bus.s_ready     = s_ready_c;
    bus.mem_wr_en   = wr_go;
    bus.mem_rd_en   = rd_go;
    bus.mem_addr    = rd_go ? rptr_reg : wptr_reg;
    bus.mem_data_in = bus.s_data;
    bus.m_valid     = m_valid_reg;
    bus.m_data      = m_data_reg;
    bus.level       = level_reg;
  end
endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Directed bench for mem_stream_ctrl: a queue-based model is compared against the DUT every cycle,
// plus literal checks of reset, fill, drain, wrap-around and reset during a read.
module tb_mem_stream_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_stream_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_stream_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 16x8 single-port memory with registered read
  logic [7:0] mem_array [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem_array[bus.mem_addr] <= bus.mem_data_in;
    if (bus.mem_rd_en) bus.mem_data_out <= mem_array[bus.mem_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: stored bytes as a queue, one read in flight, one output slot.
  logic [7:0] model_q [$];
  bit         pend;
  logic [7:0] pend_data;
  bit         out_v;
  logic [7:0] out_d;
  int         wr_cnt, rd_cnt;
  int         cyc = 0;
  logic [7:0] out_q [$];
  int         out_cyc [$];
  int         wr15, rd15;

  always begin : compare
    bit exp_rd, exp_sr, exp_wr;
    logic [3:0] exp_addr;
    @(negedge clk);
    #2;
    cyc++;
    if (reset) begin
      model_q.delete();
      pend = 0; out_v = 0; out_d = '0; wr_cnt = 0; rd_cnt = 0;
      exp_rd = 0; exp_sr = 0;
    end else begin
      exp_rd = (model_q.size() != 0) && !pend && !out_v;
      exp_sr = (model_q.size() != DEPTH) && !exp_rd;
    end
    exp_wr   = bus.s_valid && exp_sr;
    exp_addr = exp_rd ? rd_cnt[3:0] : wr_cnt[3:0];

    check("s_ready",   bus.s_ready,   exp_sr);
    check("mem_rd_en", bus.mem_rd_en, exp_rd);
    check("mem_wr_en", bus.mem_wr_en, exp_wr);
    check("mem_addr",  bus.mem_addr,  exp_addr);
    check("level",     bus.level,     model_q.size());
    check("m_valid",   bus.m_valid,   out_v);
    check("m_data",    bus.m_data,    out_d);
    check("no_collision", bus.mem_wr_en && bus.mem_rd_en, 0);
    if (!exp_rd) check("mem_data_in", bus.mem_data_in, bus.s_data);

    if (!reset && bus.m_valid && bus.m_ready) begin
      out_q.push_back(bus.m_data);
      out_cyc.push_back(cyc);
    end
    if (bus.mem_wr_en && bus.mem_addr == 4'd15) wr15++;
    if (bus.mem_rd_en && bus.mem_addr == 4'd15) rd15++;

    if (!reset) begin
      if (out_v && bus.m_ready) out_v = 0;
      if (pend) begin out_d = pend_data; out_v = 1; pend = 0; end
      if (exp_rd) begin pend_data = model_q.pop_front(); pend = 1; rd_cnt++; end
      if (exp_wr) begin model_q.push_back(bus.s_data); wr_cnt++; end
    end
  end

  // Offer one byte until accepted; starts and ends right after a falling edge.
  task automatic send(input logic [7:0] b);
    bit acc;
    int k;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    acc = 0;
    k = 0;
    while (!acc && k < 200) begin
      #3;
      acc = bus.s_ready;
      @(negedge clk);
      k++;
    end
    check("send_accept_timeout", acc, 1);
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, out_q.size() >= n, 1);
  endtask

  logic [7:0] in_list [$];

  initial begin
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    bus.m_ready = 1'b0;
    reset       = 1'b1;

    // Reset with traffic offered
    repeat (3) @(negedge clk);
    #3;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data",  bus.m_data, 0);
    check("rst_level",   bus.level, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_wr_en",   bus.mem_wr_en, 0);
    check("rst_rd_en",   bus.mem_rd_en, 0);
    check("rst_addr",    bus.mem_addr, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fill with m_ready low
    send(8'h10);
    bus.s_data = 8'h11;
    #3;
    check("fill_collide_s_ready", bus.s_ready, 0);
    check("fill_collide_rd_en",   bus.mem_rd_en, 1);
    check("fill_collide_addr",    bus.mem_addr, 0);
    @(negedge clk);
    for (int i = 8'h11; i <= 8'h20; i++) send(8'(i));
    bus.s_data = 8'h21;
    for (int i = 0; i < 4; i++) begin
      #3;
      check("fill_full_s_ready", bus.s_ready, 0);
      check("fill_full_level",   bus.level, 16);
      check("fill_full_m_valid", bus.m_valid, 1);
      check("fill_full_m_data",  bus.m_data, 8'h10);
      @(negedge clk);
    end

    // Drain
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    out_q.delete();
    out_cyc.delete();
    wait_out(17, 200, "drain_timeout");
    for (int i = 0; i < out_q.size() && i < 17; i++) begin
      check("drain_data", out_q[i], 8'h10 + i);
      if (i > 0) check("drain_spacing", out_cyc[i] - out_cyc[i-1], 3);
    end
    repeat (3) @(negedge clk);
    #3;
    check("drain_level", bus.level, 0);
    check("drain_m_valid", bus.m_valid, 0);
    @(negedge clk);

    // Wrap-around with random bytes
    out_q.delete();
    out_cyc.delete();
    wr15 = 0;
    rd15 = 0;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      in_list.push_back(b);
      send(b);
    end
    bus.s_valid = 1'b0;
    wait_out(40, 500, "wrap_timeout");
    for (int i = 0; i < out_q.size() && i < 40; i++) check("wrap_data", out_q[i], in_list[i]);
    check("wrap_wptr_twice", wr15 >= 2, 1);
    check("wrap_rptr_twice", rd15 >= 2, 1);

    // Reset while a read is in flight
    repeat (2) @(negedge clk);
    out_q.delete();
    send(8'h33);
    bus.s_valid = 1'b0;
    begin
      bit seen = 0;
      int k = 0;
      while (!seen && k < 50) begin
        #3;
        seen = bus.mem_rd_en;
        @(negedge clk);
        k++;
      end
      check("midrd_rd_seen", seen, 1);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #3;
    check("midrd_m_valid", bus.m_valid, 0);
    check("midrd_level", bus.level, 0);
    @(negedge clk);
    out_q.delete();
    send(8'h5C);
    bus.s_valid = 1'b0;
    wait_out(1, 50, "midrd_timeout");
    repeat (5) @(negedge clk);
    check("midrd_count", out_q.size(), 1);
    if (out_q.size() > 0) check("midrd_first", out_q[0], 8'h5C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
